enc_ctrl_param: RTL

ENC_CTRL_PARAM -- requirements
Module: enc_ctrl_param

---
 rtl/enc_pkg.sv | 36 +++
 rtl/enc_chan.sv | 148 ++++++++++++++
 rtl/enc_ctrl_param.sv | 100 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared register map, status-bit layout and address field view for the encoder block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

  // Register block and per-channel register offsets
  localparam logic [3:0] ADDR_MAIN     = 4'h0;
  localparam logic [3:0] OFF_ENC_LOAD  = 4'h4;
  localparam logic [3:0] OFF_ENC_CTRL  = 4'h5;
  localparam logic [3:0] OFF_ENC_DATA  = 4'h6;
  localparam logic [3:0] OFF_ENC_LATCH = 4'h7;
  localparam logic [3:0] OFF_ENC_STAT  = 4'h8;

  localparam int STAT_W = 8;

  // Bit positions inside the STAT register
  typedef enum logic [2:0] {
    STAT_IDX_LOAD_EN = 3'd0,
    STAT_OVF         = 3'd1,
    STAT_ERR         = 3'd2,
    STAT_LATCH_VLD   = 3'd3,
    STAT_DIR         = 3'd4,
    STAT_FILT_A      = 3'd5,
    STAT_FILT_B      = 3'd6,
    STAT_FILT_I      = 3'd7
  } stat_bit_e;

  // Field view of a 16-bit register address
  typedef struct packed {
    logic [3:0] blk;
    logic [3:0] rsvd;
    logic [3:0] ch;
    logic [3:0] off;
  } reg_addr_t;

endpackage

// File: rtl/enc_chan.sv
// One encoder channel: 2-FF sync, debounce, X4 quadrature decode, position counter, index latch.
// Latency: raw edge -> count change is 2 sync + DEB_CYC debounce + 1 decode cycles.
// Backpressure: none; inputs are sampled every cycle and register writes always take effect.
module enc_chan
  import enc_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int DEB_CYC = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              raw_a,
  input  logic              raw_b,
  input  logic              raw_i,
  input  logic              load_we,
  input  logic              ctrl_we,
  input  logic [CNT_W-1:0]  wdata,
  input  logic [1:0]        ctrl,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  preload,
  output logic [CNT_W-1:0]  latch,
  output logic [STAT_W-1:0] stat
);

  localparam logic [7:0]       DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = {1'b1, {(CNT_W-1){1'b0}}};

  // Bit order in the 3-bit line vectors: [0]=A, [1]=B, [2]=I
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] filt;
  logic [2:0] filt_d;
  logic [7:0] deb_cnt [3];

  logic ovf;
  logic err;
  logic latch_vld;
  logic idx_load_en;
  logic dir;

  logic a_chg;
  logic b_chg;
  logic step_vld;
  logic step_err;
  logic step_up;
  logic idx_rise;
  logic wrap;

  assign raw = {raw_i, raw_b, raw_a};

  // Two-flop synchroniser; reset seeds it with the live input so nothing looks like an edge
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= raw;
      sync2 <= raw;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the filtered level flips after DEB_CYC consecutive samples disagreeing with it
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int j = 0; j < 3; j++) deb_cnt[j] <= '0;
      filt   <= raw;
      filt_d <= raw;
    end else begin
      filt_d <= filt;
      for (int j = 0; j < 3; j++) begin
        if (sync2[j] == filt[j]) begin
          deb_cnt[j] <= '0;
        end else if (deb_cnt[j] == DEB_LAST) begin
          deb_cnt[j] <= '0;
          filt[j]    <= sync2[j];
        end else begin
          deb_cnt[j] <= deb_cnt[j] + 8'd1;
        end
      end
    end
  end

  // X4 decode on the filtered lines; A leading B (00->10->11->01) counts up
  always_comb begin
    a_chg    = filt[0] ^ filt_d[0];
    b_chg    = filt[1] ^ filt_d[1];
    step_vld = a_chg ^ b_chg;
    step_err = a_chg & b_chg;
    step_up  = a_chg ? (filt[0] ^ filt[1]) : ~(filt[0] ^ filt[1]);
    idx_rise = filt[2] & ~filt_d[2];
    wrap     = step_up ? (&count) : (count == '0);
  end

  // Counter, preload, index latch and sticky flags; register load beats index load beats step
  always_ff @(posedge sysclk) begin
    if (reset) begin
      count       <= CNT_MID;
      preload     <= CNT_MID;
      latch       <= '0;
      ovf         <= 1'b0;
      err         <= 1'b0;
      latch_vld   <= 1'b0;
      idx_load_en <= 1'b0;
      dir         <= 1'b0;
    end else begin
      if (ctrl_we) begin
        idx_load_en <= ctrl[0];
        if (ctrl[1]) begin
          ovf       <= 1'b0;
          err       <= 1'b0;
          latch_vld <= 1'b0;
        end
      end
      // New events land after a same-cycle clear so they are never lost
      if (step_err) err <= 1'b1;
      if (step_vld) dir <= step_up;
      if (idx_rise) begin
        latch     <= count;
        latch_vld <= 1'b1;
      end
      if (load_we) begin
        preload <= wdata;
        count   <= wdata;
        ovf     <= 1'b0;
      end else if (idx_rise && idx_load_en) begin
        count <= preload;
      end else if (step_vld) begin
        count <= step_up ? count + CNT_W'(1) : count - CNT_W'(1);
        if (wrap) ovf <= 1'b1;
      end
    end
  end

  // Pack the status word
  always_comb begin
    stat                   = '0;
    stat[STAT_IDX_LOAD_EN] = idx_load_en;
    stat[STAT_OVF]         = ovf;
    stat[STAT_ERR]         = err;
    stat[STAT_LATCH_VLD]   = latch_vld;
    stat[STAT_DIR]         = dir;
    stat[STAT_FILT_A]      = filt[0];
    stat[STAT_FILT_B]      = filt[1];
    stat[STAT_FILT_I]      = filt[2];
  end

endmodule

// File: rtl/enc_ctrl_param.sv
// Multi-channel quadrature encoder interface: address decode, channel array, registered read mux.
// Latency: reg_rdata one cycle after reg_raddr; writes take effect on the strobe edge; enc_pos is live.
// Backpressure: none; every write strobe and read address is accepted immediately.
module enc_ctrl_param
  import enc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int DEB_CYC = 8
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic [NUM_CH-1:0]       enc_i,
  input  logic [15:0]             reg_raddr,
  output logic [31:0]             reg_rdata,
  input  logic [15:0]             reg_waddr,
  input  logic [31:0]             reg_wdata,
  input  logic                    reg_wen,
  output logic [NUM_CH*CNT_W-1:0] enc_pos
);

  localparam logic [3:0] LAST_CH = 4'(NUM_CH);

  reg_addr_t waddr;
  reg_addr_t raddr;
  logic      wr_ok;
  logic      unused_bits;

  logic [NUM_CH-1:0] load_we;
  logic [NUM_CH-1:0] ctrl_we;
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
  logic [CNT_W-1:0]  pre_arr  [NUM_CH];
  logic [CNT_W-1:0]  lat_arr  [NUM_CH];
  logic [STAT_W-1:0] stat_arr [NUM_CH];
  logic [31:0]       rd_nxt;

  assign waddr = reg_waddr;
  assign raddr = reg_raddr;

  // Reserved address bits and write-data bits above the counter never reach a register
  assign unused_bits = ^{waddr.rsvd, raddr.rsvd, reg_wdata[31:CNT_W]};

  assign wr_ok = reg_wen && (waddr.blk == ADDR_MAIN) &&
                 (waddr.ch != 4'd0) && (waddr.ch <= LAST_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [3:0] CH_ID = 4'(g + 1);

    assign load_we[g] = wr_ok && (waddr.ch == CH_ID) && (waddr.off == OFF_ENC_LOAD);
    assign ctrl_we[g] = wr_ok && (waddr.ch == CH_ID) && (waddr.off == OFF_ENC_CTRL);

    enc_chan #(
      .CNT_W   (CNT_W),
      .DEB_CYC (DEB_CYC)
    ) u_chan (
      .sysclk  (sysclk),
      .reset   (reset),
      .raw_a   (enc_a[g]),
      .raw_b   (enc_b[g]),
      .raw_i   (enc_i[g]),
      .load_we (load_we[g]),
      .ctrl_we (ctrl_we[g]),
      .wdata   (reg_wdata[CNT_W-1:0]),
      .ctrl    (reg_wdata[1:0]),
      .count   (cnt_arr[g]),
      .preload (pre_arr[g]),
      .latch   (lat_arr[g]),
      .stat    (stat_arr[g])
    );

    assign enc_pos[g*CNT_W +: CNT_W] = cnt_arr[g];
  end

  // Read mux: anything outside the main block, channel range or defined offsets reads zero
  always_comb begin
    rd_nxt = '0;
    if (raddr.blk == ADDR_MAIN) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (raddr.ch == 4'(k + 1)) begin
          case (raddr.off)
            OFF_ENC_LOAD:  rd_nxt = 32'(pre_arr[k]);
            OFF_ENC_DATA:  rd_nxt = 32'(cnt_arr[k]);
            OFF_ENC_LATCH: rd_nxt = 32'(lat_arr[k]);
            OFF_ENC_STAT:  rd_nxt = 32'(stat_arr[k]);
            default:       rd_nxt = '0;
          endcase
        end
      end
    end
  end

  // Registered read data
  always_ff @(posedge sysclk) begin
    if (reset) reg_rdata <= '0;
    else       reg_rdata <= rd_nxt;
  end

endmodule
